// File: rtl/pwm_ramp_ctrl.sv
// PWM generator whose duty ramps toward a requested target one step every
// STEP_PERIODS PWM periods. Single +1/-1 steps may also be requested while idle.
// Duty only changes at a period boundary, so each value starts cleanly at cnt=0.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   tgt_valid    - target request valid; tgt_ready - target accepted this cycle
//   tgt_duty     - requested target duty (clamped to DUTY_MAX)
//   inc_pulse    - request +1 step; dec_pulse - request -1 step
//   duty_cycle   - current duty (registered)
//   pwm_out      - PWM waveform; period_end - last cycle of each period
//   busy         - ramping or single step pending
//   done         - one-cycle pulse when a ramp (or no-op target) completes
//   err          - one-cycle pulse after accepting an out-of-range target
module pwm_ramp_ctrl #(
    parameter int unsigned PERIOD       = 10,
    parameter int unsigned DUTY_MAX     = 10,
    parameter int unsigned DUTY_INIT    = 5,
    parameter int unsigned STEP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic [3:0] tgt_duty,
    input  logic       inc_pulse,
    input  logic       dec_pulse,
    output logic [3:0] duty_cycle,
    output logic       pwm_out,
    output logic       period_end,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned SW = 4;

    typedef enum logic {IDLE, RAMP} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   duty_d, target, target_d, clamped;
    logic [SW-1:0]   step_cnt, step_d;
    logic            pend_inc, pend_inc_d, pend_dec, pend_dec_d;
    logic            done_d, err_d;
    logic            pending, accept;

    // Period counter and waveform
    assign period_end = (cnt == CW'(PERIOD - 1));
    assign pwm_out    = (cnt < duty_cycle);

    always_ff @(posedge clk) begin
        if (rst || period_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Handshake and status
    assign pending   = pend_inc | pend_dec;
    assign busy      = (state == RAMP) | pending;
    assign tgt_ready = (state == IDLE) & ~pending;
    assign accept    = tgt_valid & tgt_ready;
    assign clamped   = (tgt_duty > DW'(DUTY_MAX)) ? DW'(DUTY_MAX) : tgt_duty;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            duty_cycle <= DW'(DUTY_INIT);
            target     <= DW'(DUTY_INIT);
            step_cnt   <= '0;
            pend_inc   <= 1'b0;
            pend_dec   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            duty_cycle <= duty_d;
            target     <= target_d;
            step_cnt   <= step_d;
            pend_inc   <= pend_inc_d;
            pend_dec   <= pend_dec_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d    = state;
        duty_d     = duty_cycle;
        target_d   = target;
        step_d     = step_cnt;
        pend_inc_d = pend_inc;
        pend_dec_d = pend_dec;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    // Target wins over same-cycle step pulses, which are dropped
                    target_d = clamped;
                    err_d    = (tgt_duty > DW'(DUTY_MAX));
                    if (clamped != duty_cycle) begin
                        state_d = RAMP;
                        step_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (pending) begin
                    // Apply the single step at the period boundary, saturating
                    if (period_end) begin
                        if (pend_inc && (duty_cycle != DW'(DUTY_MAX))) begin
                            duty_d = duty_cycle + DW'(1);
                        end
                        if (pend_dec && (duty_cycle != '0)) begin
                            duty_d = duty_cycle - DW'(1);
                        end
                        pend_inc_d = 1'b0;
                        pend_dec_d = 1'b0;
                    end
                end else if (inc_pulse ^ dec_pulse) begin
                    pend_inc_d = inc_pulse;
                    pend_dec_d = dec_pulse;
                end
            end
            RAMP: begin
                if (period_end) begin
                    if (step_cnt == SW'(STEP_PERIODS - 1)) begin
                        step_d = '0;
                        duty_d = (target > duty_cycle) ? duty_cycle + DW'(1)
                                                       : duty_cycle - DW'(1);
                        if (duty_d == target) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        step_d = step_cnt + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed self-checking bench for pwm_ramp_ctrl with default parameters.
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] tgt_duty;
    logic       inc_pulse;
    logic       dec_pulse;
    logic [3:0] duty_cycle;
    logic       pwm_out;
    logic       period_end;
    logic       busy;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_duty   (tgt_duty),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .duty_cycle (duty_cycle),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic pwm;
        logic pe;
    } pat_t;

    typedef struct {
        logic       use_tgt;
        logic [3:0] tgt;
        logic       inc;
        logic       dec;
        logic [3:0] exp_duty;
    } vec_t;

    pat_t pat [10];
    vec_t vec [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a sample shows period_end, then cross that edge
    task automatic wait_pe(input int bound);
        int n;
        n = 0;
        while (!period_end && n < bound) begin
            tick();
            n++;
        end
        if (!period_end) check("period_end_timeout", 0, 1);
        tick();
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < bound);
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int seq_idx;
        int last_chg;
        int done_cnt;
        logic prev_pe;
        logic [3:0] prev_duty;

        rst = 1'b0; tgt_valid = 1'b0; tgt_duty = 4'd0;
        inc_pulse = 1'b0; dec_pulse = 1'b0;

        // Waveform for duty 5, period 10, indexed by cnt
        for (int k = 0; k < 10; k++) pat[k] = '{pwm: (k < 5), pe: (k == 9)};

        // Single steps and ramps, applied in order starting from duty 10
        vec[0] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd10};
        vec[1] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd10};
        vec[2] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd9};
        vec[3] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd10};
        vec[4] = '{1'b1, 4'd0, 1'b0, 1'b0, 4'd0};
        vec[5] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd0};
        vec[6] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd0};
        vec[7] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd1};
        vec[8] = '{1'b1, 4'd3, 1'b0, 1'b0, 4'd3};

        // Reset state
        do_reset();
        check("rst_duty", duty_cycle, 5);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", tgt_ready, 1);

        // Two full periods at duty 5
        for (int k = 0; k < 20; k++) begin
            check("idle_pwm", pwm_out, pat[k % 10].pwm);
            check("idle_pe", period_end, pat[k % 10].pe);
            tick();
        end
        check("idle_duty", duty_cycle, 5);

        // Ramp 5 -> 8; an inc_pulse during the ramp must be ignored
        tgt_valid = 1'b1; tgt_duty = 4'd8;
        tick();
        tgt_valid = 1'b0;
        check("ramp8_busy", busy, 1);
        check("ramp8_ready", tgt_ready, 0);
        check("ramp8_err", err, 0);
        seq_idx = 0; last_chg = 0; done_cnt = 0;
        for (int cyc = 0; cyc < 180; cyc++) begin
            prev_pe   = period_end;
            prev_duty = duty_cycle;
            inc_pulse = (cyc == 5);
            tick();
            if (done) done_cnt++;
            if (duty_cycle != prev_duty) begin
                check("ramp8_align", prev_pe, 1);
                check("ramp8_value", duty_cycle, 6 + seq_idx);
                if (seq_idx > 0) check("ramp8_spacing", cyc - last_chg, 40);
                last_chg = cyc;
                seq_idx++;
            end
        end
        inc_pulse = 1'b0;
        check("ramp8_steps", seq_idx, 3);
        check("ramp8_done_cnt", done_cnt, 1);
        check("ramp8_final", duty_cycle, 8);
        check("ramp8_busy_after", busy, 0);

        // Out-of-range target clamps to 10 and flags err for one cycle
        tgt_valid = 1'b1; tgt_duty = 4'd12;
        tick();
        tgt_valid = 1'b0;
        check("clamp_err", err, 1);
        tick();
        check("clamp_err_clear", err, 0);
        wait_done(300);
        check("clamp_duty", duty_cycle, 10);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("clamp_pwm_high", pwm_out, 1);
        end

        // Step / target vector table
        for (int i = 0; i < 9; i++) begin
            if (vec[i].use_tgt) begin
                tgt_valid = 1'b1; tgt_duty = vec[i].tgt;
                tick();
                tgt_valid = 1'b0;
                wait_done(1000);
            end else begin
                inc_pulse = vec[i].inc; dec_pulse = vec[i].dec;
                tick();
                inc_pulse = 1'b0; dec_pulse = 1'b0;
                check("vec_busy_latch", busy, vec[i].inc ^ vec[i].dec);
                wait_pe(20);
                wait_pe(20);
            end
            check("vec_duty", duty_cycle, vec[i].exp_duty);
            check("vec_busy_end", busy, 0);
        end

        // Reset in the middle of a 5 -> 9 ramp
        do_reset();
        check("rst2_duty", duty_cycle, 5);
        tgt_valid = 1'b1; tgt_duty = 4'd9;
        tick();
        tgt_valid = 1'b0;
        for (int k = 0; k < 60; k++) tick();
        check("midramp_duty", duty_cycle, 6);
        check("midramp_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_duty", duty_cycle, 5);
        check("midrst_busy", busy, 0);
        check("midrst_ready", tgt_ready, 1);
        check("midrst_done", done, 0);
        done_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_duty_hold", duty_cycle, 5);

        // Target equal to duty with a same-cycle inc_pulse
        tgt_valid = 1'b1; tgt_duty = 4'd5; inc_pulse = 1'b1;
        tick();
        tgt_valid = 1'b0; inc_pulse = 1'b0;
        check("same_done", done, 1);
        check("same_busy", busy, 0);
        check("same_err", err, 0);
        tick();
        check("same_done_clear", done, 0);
        wait_pe(20);
        wait_pe(20);
        check("same_duty", duty_cycle, 5);
        check("same_busy_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 10: PWM period in clk cycles, range 2..15.
REQ-002 SHALL have parameter DUTY_MAX, default 10: maximum duty in steps, equal to PERIOD.
REQ-003 SHALL have parameter DUTY_INIT, default 5: duty after reset (50%).
REQ-004 SHALL have parameter STEP_PERIODS, default 4: PWM periods per ramp step, range 1..15.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port tgt_valid, input, 1: target duty request valid.
REQ-008 SHALL have port tgt_ready, output, 1: controller accepts a target this cycle.
REQ-009 SHALL have port tgt_duty, input, 4: requested target duty in steps.
REQ-010 SHALL have port inc_pulse, input, 1: single-cycle request for +1 step (debounced upstream).
REQ-011 SHALL have port dec_pulse, input, 1: single-cycle request for -1 step.
REQ-012 SHALL have port duty_cycle, output, 4: current duty, registered.
REQ-013 SHALL have port pwm_out, output, 1: PWM waveform.
REQ-014 SHALL have port period_end, output, 1: high on the last cycle of each PWM period.
REQ-015 SHALL have port busy, output, 1: high while in RAMP or while a single step is pending.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when a ramp reaches its target.
REQ-017 SHALL have port err, output, 1: one-cycle pulse when an out-of-range target is accepted.

Function
REQ-018 SHALL implement a period counter cnt that runs 0..PERIOD-1 and wraps to 0; period_end SHALL be (cnt == PERIOD-1), combinational.
REQ-019 SHALL drive pwm_out = (cnt < duty_cycle): duty 0 gives constant low; duty DUTY_MAX gives constant high.
REQ-020 SHALL change duty_cycle only on the clock edge where period_end=1, so each new value takes effect from cnt=0 (no mid-period glitch).
REQ-021 SHALL implement an FSM with states IDLE and RAMP.
REQ-022 SHALL drive tgt_ready=1 only in IDLE with no pending single step.
REQ-023 SHALL accept a target when tgt_valid & tgt_ready; on accept, the target register SHALL load min(tgt_duty, DUTY_MAX).
REQ-024 SHALL pulse err for one cycle, on the cycle after accept, when tgt_duty > DUTY_MAX.
REQ-025 SHALL go to RAMP on accept when the clamped target != duty_cycle, and SHALL clear the step counter to 0.
REQ-026 SHALL stay in IDLE on accept when the clamped target == duty_cycle, and SHALL pulse done one cycle later.
REQ-027 SHALL, in RAMP, increment the step counter on each period_end.
REQ-028 SHALL, in RAMP, move duty_cycle one step toward the target when period_end=1 and step counter == STEP_PERIODS-1, then clear the step counter.
REQ-029 SHALL, when the ramp step makes duty_cycle equal the target, pulse done on the next cycle and return to IDLE.
REQ-030 SHALL, in IDLE with no pending step, latch a pending +1 on inc_pulse=1 alone and a pending -1 on dec_pulse=1 alone.
REQ-031 SHALL ignore inc_pulse and dec_pulse when both are asserted in the same cycle.
REQ-032 SHALL apply a pending step at the next period_end, then clear it.
REQ-033 SHALL saturate steps: +1 at DUTY_MAX and -1 at 0 leave duty unchanged and still clear the pending step.
REQ-034 SHALL give tgt_valid priority over inc_pulse/dec_pulse in the same cycle; the pulses are then dropped.
REQ-035 SHALL ignore inc_pulse and dec_pulse while busy=1.
REQ-036 SHALL not generate done for single steps.

Reset
REQ-037 SHALL, on rst=1 at a clock edge, set cnt=0, duty_cycle=DUTY_INIT, target=DUTY_INIT, step counter=0, state=IDLE, and clear the pending step.
REQ-038 SHALL hold done=0, err=0, busy=0, and tgt_ready=1 on the cycle after reset.
REQ-039 SHALL, on rst mid-ramp, abandon the ramp without a done pulse.

Verification
REQ-040 Bench SHALL cover: reset, then 20 cycles -> duty_cycle=5, pwm_out high for cnt 0..4 and low for cnt 5..9, period_end every 10th cycle.
REQ-041 Bench SHALL cover: target 8 accepted, defaults -> duty 6, 7, 8 at 40-cycle spacing aligned to period_end; done once; busy low after.
REQ-042 Bench SHALL cover: target 12 accepted -> err pulse; ramp to 10; pwm_out constant high.
REQ-043 Bench SHALL cover: inc_pulse at duty 10 -> duty stays 10; dec_pulse at 0 -> stays 0; inc and dec in the same cycle -> no change.
REQ-044 Bench SHALL cover: rst asserted mid-ramp 5->9 -> duty=5 and state IDLE next cycle; no done pulse.
REQ-045 Bench SHALL cover: tgt_valid and inc_pulse in the same cycle at duty 5, target 5 -> done pulse; duty stays 5.
